// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
// SPI mode-0 style master: shifts WIDTH bits out on mosi (MSB first) while
// capturing WIDTH bits from miso, with sclk derived from the system clock by a
// programmable divider. All outputs come straight from registers.
//
// Parameters
//   WIDTH    bits per transaction
//   CLK_DIV  system clocks per sclk half-period (>= 1)
//
// Ports
//   clock    in   system clock, rising-edge active
//   reset    in   synchronous, active-high reset
//   start    in   transaction request, sampled only while idle
//   tx_data  in   word to transmit, latched when a transaction starts
//   rx_data  out  last complete word received, updated with done
//   busy     out  transaction in progress
//   done     out  one-cycle pulse when rx_data updates
//   sclk     out  SPI clock, idle low
//   ssel     out  slave select, active low, idle high
//   mosi     out  serial data to slave, idle high
//   miso     in   serial data from slave
// -----------------------------------------------------------------------------
module spi_master #(
    parameter int WIDTH   = 10,
    parameter int CLK_DIV = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy,
    output logic             done,
    output logic             sclk,
    output logic             ssel,
    output logic             mosi,
    input  logic             miso
);

    // Counters need at least one bit even when the range collapses to 0..0.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t           r_state,    w_state_next;
    logic [DIV_W-1:0] r_div_cnt,  w_div_cnt_next;
    logic [BIT_W-1:0] r_bit_cnt,  w_bit_cnt_next;
    logic [WIDTH-1:0] r_tx_shift, w_tx_shift_next;
    logic [WIDTH-1:0] r_rx_shift, w_rx_shift_next;
    logic [WIDTH-1:0] r_rx_data,  w_rx_data_next;
    logic             r_busy,     w_busy_next;
    logic             r_done,     w_done_next;
    logic             r_sclk,     w_sclk_next;
    logic             r_ssel,     w_ssel_next;
    logic             r_mosi,     w_mosi_next;

    logic             w_div_last;
    logic [WIDTH-1:0] w_tx_shifted;
    logic [WIDTH-1:0] w_rx_shifted;

    assign w_div_last   = (r_div_cnt == DIV_LAST);
    assign w_tx_shifted = r_tx_shift << 1;
    // Keep the low WIDTH bits: oldest bit falls off the top, miso enters at LSB.
    assign w_rx_shifted = WIDTH'({r_rx_shift, miso});

    assign rx_data = r_rx_data;
    assign busy    = r_busy;
    assign done    = r_done;
    assign sclk    = r_sclk;
    assign ssel    = r_ssel;
    assign mosi    = r_mosi;

    // State and output registers; reset returns everything to the idle picture.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sclk     <= 1'b0;
            r_ssel     <= 1'b1;
            r_mosi     <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_div_cnt  <= w_div_cnt_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_tx_shift <= w_tx_shift_next;
            r_rx_shift <= w_rx_shift_next;
            r_rx_data  <= w_rx_data_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_sclk     <= w_sclk_next;
            r_ssel     <= w_ssel_next;
            r_mosi     <= w_mosi_next;
        end
    end

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        w_state_next    = r_state;
        w_div_cnt_next  = r_div_cnt;
        w_bit_cnt_next  = r_bit_cnt;
        w_tx_shift_next = r_tx_shift;
        w_rx_shift_next = r_rx_shift;
        w_rx_data_next  = r_rx_data;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;
        w_sclk_next     = r_sclk;
        w_ssel_next     = r_ssel;
        w_mosi_next     = r_mosi;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_tx_shift_next = tx_data;
                    w_div_cnt_next  = '0;
                    w_bit_cnt_next  = '0;
                    w_ssel_next     = 1'b0;
                    w_busy_next     = 1'b1;
                    w_mosi_next     = tx_data[WIDTH-1];
                    w_state_next    = ST_LOW;
                end else begin
                    w_state_next    = ST_IDLE;
                end
            end

            ST_LOW: begin
                if (w_div_last) begin
                    // Rising sclk edge: miso is captured on the same edge.
                    w_div_cnt_next  = '0;
                    w_sclk_next     = 1'b1;
                    w_rx_shift_next = w_rx_shifted;
                    w_state_next    = ST_HIGH;
                end else begin
                    w_div_cnt_next  = r_div_cnt + DIV_W'(1);
                end
            end

            ST_HIGH: begin
                if (w_div_last) begin
                    w_div_cnt_next = '0;
                    w_sclk_next    = 1'b0;
                    if (r_bit_cnt == BIT_LAST) begin
                        // Last bit stays on mosi through the hold phase.
                        w_state_next    = ST_HOLD;
                    end else begin
                        w_bit_cnt_next  = r_bit_cnt + BIT_W'(1);
                        w_tx_shift_next = w_tx_shifted;
                        w_mosi_next     = w_tx_shifted[WIDTH-1];
                        w_state_next    = ST_LOW;
                    end
                end else begin
                    w_div_cnt_next = r_div_cnt + DIV_W'(1);
                end
            end

            ST_HOLD: begin
                if (w_div_last) begin
                    w_div_cnt_next = '0;
                    w_ssel_next    = 1'b1;
                    w_mosi_next    = 1'b1;
                    w_busy_next    = 1'b0;
                    w_done_next    = 1'b1;
                    w_rx_data_next = r_rx_shift;
                    w_state_next   = ST_IDLE;
                end else begin
                    w_div_cnt_next = r_div_cnt + DIV_W'(1);
                end
            end

            default: begin
                w_state_next   = ST_IDLE;
                w_div_cnt_next = '0;
                w_bit_cnt_next = '0;
                w_busy_next    = 1'b0;
                w_sclk_next    = 1'b0;
                w_ssel_next    = 1'b1;
                w_mosi_next    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
// Self-checking bench for spi_master. Two instances share one clock: dut_a
// uses the default divider (4), dut_b the minimum divider (1). Expected pin
// values are computed per cycle from the documented sclk/ssel schedule; a
// slave model feeds miso one bit per sclk rise.
// -----------------------------------------------------------------------------
module tb_spi_master;

    localparam int W  = 10;
    localparam int DA = 4;
    localparam int DB = 1;

    typedef struct packed {
        logic ssel;
        logic sclk;
        logic mosi;
        logic busy;
        logic done;
    } outs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         a_reset, a_start, a_miso, a_busy, a_done, a_sclk, a_ssel, a_mosi;
    logic [W-1:0] a_tx, a_rx;
    logic         b_reset, b_start, b_miso, b_busy, b_done, b_sclk, b_ssel, b_mosi;
    logic [W-1:0] b_tx, b_rx;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_rx_a = '0;
    logic [W-1:0] exp_rx_b = '0;

    spi_master #(.WIDTH(W), .CLK_DIV(DA)) dut_a (
        .clock(clk), .reset(a_reset), .start(a_start), .tx_data(a_tx),
        .rx_data(a_rx), .busy(a_busy), .done(a_done), .sclk(a_sclk),
        .ssel(a_ssel), .mosi(a_mosi), .miso(a_miso)
    );

    spi_master #(.WIDTH(W), .CLK_DIV(DB)) dut_b (
        .clock(clk), .reset(b_reset), .start(b_start), .tx_data(b_tx),
        .rx_data(b_rx), .busy(b_busy), .done(b_done), .sclk(b_sclk),
        .ssel(b_ssel), .mosi(b_mosi), .miso(b_miso)
    );

    // Advance one clock and land just after the edge (sampling and driving point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: pin values t cycles after the start edge, from the edge schedule
    // (rise at div*(2k+1), fall at div*(2k+2), done at div*(2W+1)).
    function automatic outs_t model(input int t, input int div, input logic [W-1:0] tx);
        outs_t o;
        int last;
        int phase;
        last = div * (2 * W + 1);
        if (t >= last) begin
            o.ssel = 1'b1; o.sclk = 1'b0; o.mosi = 1'b1; o.busy = 1'b0;
            o.done = (t == last) ? 1'b1 : 1'b0;
        end else begin
            o.ssel = 1'b0; o.busy = 1'b1; o.done = 1'b0;
            phase  = t / div;
            if (phase < 2 * W) begin
                o.sclk = (phase % 2 == 1) ? 1'b1 : 1'b0;
                o.mosi = tx[W - 1 - phase / 2];
            end else begin
                o.sclk = 1'b0;
                o.mosi = tx[0];
            end
        end
        return o;
    endfunction

    task automatic test_reset();
        a_reset = 1'b1; b_reset = 1'b1;
        a_start = 1'b0; b_start = 1'b0;
        tick();
        tick();
        checks++;
        if ({a_ssel, a_sclk, a_mosi, a_busy, a_done} !== 5'b10100) begin
            errors++;
            $display("FAIL reset_pins_a got=%b expected=%b", {a_ssel, a_sclk, a_mosi, a_busy, a_done}, 5'b10100);
        end
        checks++;
        if (a_rx !== '0) begin
            errors++;
            $display("FAIL reset_rx_a got=%h expected=000", a_rx);
        end
        checks++;
        if ({b_ssel, b_sclk, b_mosi, b_busy, b_done} !== 5'b10100 || b_rx !== '0) begin
            errors++;
            $display("FAIL reset_b got=%b/%h expected=10100/000", {b_ssel, b_sclk, b_mosi, b_busy, b_done}, b_rx);
        end
        a_reset = 1'b0; b_reset = 1'b0;
        exp_rx_a = '0; exp_rx_b = '0;
        tick();
    endtask

    // One transaction on dut_a; mid=1 also changes tx_data and pulses start while busy.
    task automatic test_transfer(input logic [W-1:0] tx, input logic [W-1:0] slave, input bit mid);
        int last;
        int rises;
        logic prev;
        logic [W-1:0] got;
        logic [W-1:0] erx;
        outs_t e;
        last = DA * (2 * W + 1);
        rises = 0; prev = 1'b0; got = '0;
        a_tx = tx; a_miso = slave[W-1]; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int t = 0; t <= last + 3; t++) begin
            e = model(t, DA, tx);
            checks++;
            if ({a_ssel, a_sclk, a_mosi, a_busy, a_done} !== e) begin
                errors++;
                $display("FAIL xfer_pins tx=%h t=%0d got=%b expected=%b", tx, t, {a_ssel, a_sclk, a_mosi, a_busy, a_done}, e);
            end
            erx = (t >= last) ? slave : exp_rx_a;
            checks++;
            if (a_rx !== erx) begin
                errors++;
                $display("FAIL xfer_rx tx=%h t=%0d got=%h expected=%h", tx, t, a_rx, erx);
            end
            if (a_sclk === 1'b1 && prev === 1'b0) begin
                got = {got[W-2:0], a_mosi};
                rises++;
            end
            prev = a_sclk;
            a_miso = (rises < W) ? slave[W - 1 - rises] : 1'b0;
            if (mid && t == 9)  a_tx = '0;
            if (mid && t == 19) a_start = 1'b1;
            if (mid && t == 20) a_start = 1'b0;
            tick();
        end
        exp_rx_a = slave;
        checks++;
        if (got !== tx || rises != W) begin
            errors++;
            $display("FAIL xfer_serial got=%h/%0d expected=%h/%0d", got, rises, tx, W);
        end
    endtask

    task automatic test_back_to_back();
        int last;
        int fall_t;
        int done_t[$];
        logic prev_ssel;
        logic [W-1:0] erx;
        outs_t e;
        last = DA * (2 * W + 1);
        fall_t = -1; prev_ssel = 1'b0;
        a_miso = 1'b1; a_tx = {W{1'b1}}; a_start = 1'b1;
        tick();
        for (int t = 0; t <= 2 * last + 3; t++) begin
            if (t <= last) e = model(t, DA, {W{1'b1}});
            else           e = model(t - last - 1, DA, {W{1'b0}});
            checks++;
            if ({a_ssel, a_sclk, a_mosi, a_busy, a_done} !== e) begin
                errors++;
                $display("FAIL b2b_pins t=%0d got=%b expected=%b", t, {a_ssel, a_sclk, a_mosi, a_busy, a_done}, e);
            end
            erx = (t >= last) ? {W{1'b1}} : exp_rx_a;
            checks++;
            if (a_rx !== erx) begin
                errors++;
                $display("FAIL b2b_rx t=%0d got=%h expected=%h", t, a_rx, erx);
            end
            if (a_done === 1'b1) done_t.push_back(t);
            if (t > 0 && a_ssel === 1'b0 && prev_ssel === 1'b1) fall_t = t;
            prev_ssel = a_ssel;
            if (t == last)     a_tx = '0;
            if (t == last + 1) a_start = 1'b0;
            tick();
        end
        exp_rx_a = {W{1'b1}};
        checks++;
        if (done_t.size() != 2) begin
            errors++;
            $display("FAIL b2b_done_count got=%0d expected=2", done_t.size());
        end else begin
            checks++;
            if (done_t[1] - done_t[0] != last + 1) begin
                errors++;
                $display("FAIL b2b_done_gap got=%0d expected=%0d", done_t[1] - done_t[0], last + 1);
            end
        end
        checks++;
        if (fall_t != last + 1) begin
            errors++;
            $display("FAIL b2b_ssel_fall got=%0d expected=%0d", fall_t, last + 1);
        end
    endtask

    task automatic test_reset_mid();
        outs_t e;
        a_tx = W'(12'h155); a_miso = 1'b1; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (t < 39) begin
                e = model(t, DA, W'(12'h155));
                checks++;
                if ({a_ssel, a_sclk, a_mosi, a_busy, a_done} !== e) begin
                    errors++;
                    $display("FAIL rstmid_pins t=%0d got=%b expected=%b", t, {a_ssel, a_sclk, a_mosi, a_busy, a_done}, e);
                end
            end else begin
                a_reset = 1'b1;
            end
            a_miso = 1'($urandom());
            tick();
        end
        checks++;
        if ({a_ssel, a_sclk, a_mosi, a_busy, a_done} !== 5'b10100 || a_rx !== '0) begin
            errors++;
            $display("FAIL rstmid_idle got=%b/%h expected=10100/000", {a_ssel, a_sclk, a_mosi, a_busy, a_done}, a_rx);
        end
        a_reset = 1'b0;
        exp_rx_a = '0;
        for (int t = 0; t < 100; t++) begin
            tick();
            checks++;
            if (a_done !== 1'b0 || a_ssel !== 1'b1 || a_rx !== '0) begin
                errors++;
                $display("FAIL rstmid_quiet t=%0d got=%b%b/%h expected=01/000", t, a_done, a_ssel, a_rx);
            end
        end
        // Reset and start together: reset wins.
        a_reset = 1'b1; a_start = 1'b1;
        tick();
        checks++;
        if (a_busy !== 1'b0 || a_ssel !== 1'b1) begin
            errors++;
            $display("FAIL rst_priority got=%b%b expected=01", a_busy, a_ssel);
        end
        a_reset = 1'b0; a_start = 1'b0;
        tick();
    endtask

    task automatic test_min_divider();
        logic [W-1:0] txs[2];
        logic [W-1:0] slaves[2];
        int last;
        int rises;
        logic [W-1:0] erx;
        outs_t e;
        last = DB * (2 * W + 1);
        txs[0] = W'(12'h200); slaves[0] = {W{1'b1}};
        txs[1] = W'($urandom()); slaves[1] = W'($urandom());
        for (int n = 0; n < 2; n++) begin
            rises = 0;
            b_tx = txs[n]; b_miso = slaves[n][W-1]; b_start = 1'b1;
            tick();
            b_start = 1'b0;
            for (int t = 0; t <= last + 2; t++) begin
                e = model(t, DB, txs[n]);
                checks++;
                if ({b_ssel, b_sclk, b_mosi, b_busy, b_done} !== e) begin
                    errors++;
                    $display("FAIL mindiv_pins n=%0d t=%0d got=%b expected=%b", n, t, {b_ssel, b_sclk, b_mosi, b_busy, b_done}, e);
                end
                erx = (t >= last) ? slaves[n] : exp_rx_b;
                checks++;
                if (b_rx !== erx) begin
                    errors++;
                    $display("FAIL mindiv_rx n=%0d t=%0d got=%h expected=%h", n, t, b_rx, erx);
                end
                if (b_sclk === 1'b1) rises++;
                b_miso = (rises < W) ? slaves[n][W - 1 - rises] : 1'b0;
                tick();
            end
            exp_rx_b = slaves[n];
        end
    endtask

    initial begin
        a_reset = 1'b0; a_start = 1'b0; a_tx = '0; a_miso = 1'b0;
        b_reset = 1'b0; b_start = 1'b0; b_tx = '0; b_miso = 1'b0;
        test_reset();
        test_transfer(W'(12'h155), W'(12'h2AA), 1'b0);
        for (int i = 0; i < 4; i++) begin
            test_transfer(W'($urandom()), W'($urandom()), 1'b0);
        end
        test_transfer(W'(12'h155), W'($urandom()), 1'b1);
        test_back_to_back();
        test_reset_mid();
        test_min_divider();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
